spi_slave_fifo: RTL and testbench

//  Parametrised successor to the byte-wide SPI slave. Supports DATA_W-bit words and all four CPOL/CPHA modes.

---
 rtl/spi_slave_fifo_pkg.sv | 17 +
 rtl/spi_slave_fifo_if.sv | 19 +
 rtl/spi_slave_fifo_sync_fifo.sv | 40 ++++
 rtl/spi_slave_fifo.sv | 142 ++++++++++++++
 tb/tb_spi_slave_fifo.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_fifo_pkg.sv
// spi_pkg: frame states, synchroniser depth and CPOL/CPHA edge mapping for spi_slave_fifo.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t;
    localparam int SYNC_STAGES = 2;
    function automatic logic lead_edge(input logic cpol, input logic prev, input logic cur);
        return cpol ? (prev && !cur) : (!prev && cur);
    endfunction
    function automatic logic trail_edge(input logic cpol, input logic prev, input logic cur);
        return cpol ? (!prev && cur) : (prev && !cur);
    endfunction
    function automatic logic sample_edge(input logic cpha, input logic lead, input logic trail);
        return cpha ? trail : lead;
    endfunction
    function automatic logic shift_edge(input logic cpha, input logic lead, input logic trail);
        return cpha ? lead : trail;
    endfunction
endpackage

// File: rtl/spi_slave_fifo_if.sv
// spi_slave_fifo_if: RX/TX word handshakes and FIFO levels between spi_slave_fifo and its controller.
interface spi_slave_fifo_if #(
    parameter int DATA_W = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
);
    logic [DATA_W-1:0] rx_data, tx_data;
    logic rx_valid, rx_ready, tx_valid, tx_ready;
    logic [$clog2(RX_DEPTH):0] rx_level;
    logic [$clog2(TX_DEPTH):0] tx_level;
    modport slave (
        output rx_data, rx_valid, rx_level, tx_ready, tx_level,
        input  rx_ready, tx_data, tx_valid
    );
    modport master (
        input  rx_data, rx_valid, rx_level, tx_ready, tx_level,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_slave_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy level.
module sync_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] level_q;
    logic do_push, do_pop;
    assign empty = level_q == '0;
    assign full = level_q == (AW+1)'(DEPTH);
    // a pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem_q[rd_q];
    assign level = level_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave for any CPOL/CPHA with RX/TX word FIFOs.
// Define SPI_SLAVE_FIFO_STATUS_EN for sticky overrun/underrun flags and a frame counter.
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    spi_slave_fifo_if.slave bus,
    output logic busy,
    output logic word_done
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    ,
    output logic rx_overrun,
    output logic tx_underrun,
    input  logic status_clr,
    output logic [15:0] frame_cnt
`endif
);
    localparam int CW = $clog2(DATA_W);
    spi_state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
    logic ss_s, sck_s, mosi_s, ss_prev_q, sck_prev_q, sample, shift;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d, tx_head, load_word;
    logic miso_q, miso_d, word_done_q, boundary, reload;
    logic rx_push, rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty;
    assign ss_s = ss_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign sample = sample_edge(CPHA, lead_edge(CPOL, sck_prev_q, sck_s), trail_edge(CPOL, sck_prev_q, sck_s));
    assign shift = shift_edge(CPHA, lead_edge(CPOL, sck_prev_q, sck_s), trail_edge(CPOL, sck_prev_q, sck_s));
    assign load_word = tx_empty ? IDLE_WORD : tx_head;
    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        miso_d = miso_q;
        boundary = 1'b0;
        reload = 1'b0;
        if (ss_s) begin
            state_d = IDLE;
            bit_cnt_d = '0;
            miso_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ss_prev_q ? LOAD : IDLE;
        end else if (state_q == LOAD) begin
            reload = 1'b1;
            state_d = SHIFT;
        end else begin
            if (sample) begin
                shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
                boundary = bit_cnt_q == CW'(DATA_W - 1);
                bit_cnt_d = boundary ? '0 : bit_cnt_q + CW'(1);
                reload = boundary;
            end
            // with CPHA=0 the trailing edge right after a reload must keep the freshly presented MSB
            if (shift && (CPHA || bit_cnt_q != '0)) begin
                miso_d = shift_tx_q[DATA_W-1];
                shift_tx_d = shift_tx_q << 1;
            end
        end
        if (reload) begin
            shift_tx_d = CPHA ? load_word : load_word << 1;
            miso_d = CPHA ? miso_q : load_word[DATA_W-1];
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ss_sync_q <= '1;
            sck_sync_q <= {SYNC_STAGES{CPOL}};
            mosi_sync_q <= '0;
            ss_prev_q <= 1'b1;
            sck_prev_q <= CPOL;
            state_q <= IDLE;
            bit_cnt_q <= '0;
            shift_rx_q <= '0;
            shift_tx_q <= '0;
            miso_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            ss_sync_q <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_prev_q <= ss_s;
            sck_prev_q <= sck_s;
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_rx_q <= shift_rx_d;
            shift_tx_q <= shift_tx_d;
            miso_q <= miso_d;
            word_done_q <= boundary;
        end
    assign rx_pop = bus.rx_ready && !rx_empty;
    assign rx_push = word_done_q && (!rx_full || rx_pop);
    assign tx_push = bus.tx_valid && !tx_full;
    assign tx_pop = reload && !tx_empty;
    sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(shift_rx_q),
        .dout(bus.rx_data), .full(rx_full), .empty(rx_empty), .level(bus.rx_level)
    );
    sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.tx_data),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(bus.tx_level)
    );
    assign bus.rx_valid = !rx_empty;
    assign bus.tx_ready = !tx_full;
    // masked by the raw pin so miso releases as soon as the master deselects
    assign miso = miso_q && !ss;
    assign busy = !ss_s;
    assign word_done = word_done_q;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    logic rx_overrun_q, tx_underrun_q, got_word_q;
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_overrun_q <= 1'b0;
            tx_underrun_q <= 1'b0;
            got_word_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            rx_overrun_q <= (word_done_q && !rx_push) || (rx_overrun_q && !status_clr);
            tx_underrun_q <= (reload && tx_empty) || (tx_underrun_q && !status_clr);
            got_word_q <= !ss_s && (got_word_q || boundary);
            if (ss_s && !ss_prev_q && got_word_q) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    assign rx_overrun = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed bench for spi_slave_fifo; one 8-bit mode-0 slave plus four 16-bit slaves (modes 0-3).
module tb_spi_slave_fifo;
    localparam int H = 80;
    logic clk = 1'b0, rst = 1'b1, mosi = 1'b0;
    logic [4:0] ss_p = 5'b11111, sck_p = 5'b01100, miso_p;
    logic busy8, wd8;
    logic [3:0] busy16, wd16, rx_ready16 = '0, tx_valid16 = '0;
    logic [15:0] tx_data16 [4];
    logic [15:0] rx_data16 [4];
    logic [2:0] rx_level16 [4];
    int chk = 0, pass = 0, wd_cnt = 0;
    logic [15:0] mi;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    logic ov8, un8, clr8 = 1'b0;
    logic [15:0] fc8;
`endif
    always #5 clk = ~clk;
    always @(posedge clk) if (wd8) wd_cnt <= wd_cnt + 1;

    spi_slave_fifo_if #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(4)) if8();
    spi_slave_fifo #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .IDLE_WORD(8'hFF)) u8 (
        .clk(clk), .rst(rst), .ss(ss_p[4]), .sck(sck_p[4]), .mosi(mosi), .miso(miso_p[4]),
        .bus(if8.slave), .busy(busy8), .word_done(wd8)
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        , .rx_overrun(ov8), .tx_underrun(un8), .status_clr(clr8), .frame_cnt(fc8)
`endif
    );

    for (genvar g = 0; g < 4; g++) begin : g16
        spi_slave_fifo_if #(.DATA_W(16), .RX_DEPTH(4), .TX_DEPTH(4)) ifc();
        assign ifc.rx_ready = rx_ready16[g];
        assign ifc.tx_valid = tx_valid16[g];
        assign ifc.tx_data = tx_data16[g];
        assign rx_data16[g] = ifc.rx_data;
        assign rx_level16[g] = ifc.rx_level;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        logic ov, un;
        logic [15:0] fc;
`endif
        spi_slave_fifo #(.DATA_W(16), .RX_DEPTH(4), .TX_DEPTH(4), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
            .clk(clk), .rst(rst), .ss(ss_p[g]), .sck(sck_p[g]), .mosi(mosi), .miso(miso_p[g]),
            .bus(ifc.slave), .busy(busy16[g]), .word_done(wd16[g])
`ifdef SPI_SLAVE_FIFO_STATUS_EN
            , .rx_overrun(ov), .tx_underrun(un), .status_clr(1'b0), .frame_cnt(fc)
`endif
        );
    end

    task automatic frame_begin(input int m);
        ss_p[m] = 1'b0;
        #100;
    endtask

    task automatic frame_end(input int m);
        #H;
        ss_p[m] = 1'b1;
        #200;
        @(negedge clk);
    endtask

    // master side: shifts nb bits of mo MSB first, returns what it sampled on miso
    task automatic xfer(input int m, input int nb, input logic [15:0] mo, output logic [15:0] r);
        logic cpol, cpha;
        cpol = (m == 2 || m == 3);
        cpha = (m == 1 || m == 3);
        r = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                #H;
                r[i] = miso_p[m];
                sck_p[m] = ~cpol;
                #H;
                sck_p[m] = cpol;
            end else begin
                sck_p[m] = ~cpol;
                mosi = mo[i];
                #H;
                r[i] = miso_p[m];
                sck_p[m] = cpol;
                #H;
            end
        end
    endtask

    task automatic push8(input logic [7:0] d);
        @(negedge clk);
        if8.tx_data = d;
        if8.tx_valid = 1'b1;
        @(negedge clk);
        if8.tx_valid = 1'b0;
    endtask

    task automatic pop8();
        @(negedge clk);
        if8.rx_ready = 1'b1;
        @(negedge clk);
        if8.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        chk++; if (miso_p !== 5'b0) $display("FAIL reset_miso got %b exp 00000", miso_p); else pass++;
        chk++; if (if8.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", if8.rx_valid); else pass++;
        chk++; if (if8.tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", if8.tx_ready); else pass++;
        chk++; if (if8.rx_level !== 3'd0) $display("FAIL reset_rx_level got %0d exp 0", if8.rx_level); else pass++;
        chk++; if (if8.tx_level !== 3'd0) $display("FAIL reset_tx_level got %0d exp 0", if8.tx_level); else pass++;
        chk++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy8); else pass++;
        chk++; if (wd8 !== 1'b0) $display("FAIL reset_word_done got %b exp 0", wd8); else pass++;
    endtask

    task automatic test_mode0();
        int base;
        push8(8'hA5);
        chk++; if (if8.tx_level !== 3'd1) $display("FAIL m0_tx_level got %0d exp 1", if8.tx_level); else pass++;
        base = wd_cnt;
        frame_begin(4);
        chk++; if (busy8 !== 1'b1) $display("FAIL m0_busy got %b exp 1", busy8); else pass++;
        xfer(4, 8, 16'h003C, mi);
        frame_end(4);
        chk++; if (mi[7:0] !== 8'hA5) $display("FAIL m0_miso got %h exp a5", mi[7:0]); else pass++;
        chk++; if (wd_cnt - base !== 1) $display("FAIL m0_word_done got %0d exp 1", wd_cnt - base); else pass++;
        chk++; if (if8.rx_data !== 8'h3C) $display("FAIL m0_rx_data got %h exp 3c", if8.rx_data); else pass++;
        chk++; if (if8.rx_valid !== 1'b1) $display("FAIL m0_rx_valid got %b exp 1", if8.rx_valid); else pass++;
        chk++; if (if8.rx_level !== 3'd1) $display("FAIL m0_rx_level got %0d exp 1", if8.rx_level); else pass++;
        pop8();
        chk++; if (if8.rx_level !== 3'd0) $display("FAIL m0_pop_level got %0d exp 0", if8.rx_level); else pass++;
    endtask

    task automatic test_modes16();
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            tx_data16[m] = 16'h1234;
            tx_valid16[m] = 1'b1;
            @(negedge clk);
            tx_valid16[m] = 1'b0;
            frame_begin(m);
            xfer(m, 16, 16'hBEEF, mi);
            frame_end(m);
            chk++; if (mi !== 16'h1234) $display("FAIL mode%0d_miso got %h exp 1234", m, mi); else pass++;
            chk++; if (rx_data16[m] !== 16'hBEEF) $display("FAIL mode%0d_rx_data got %h exp beef", m, rx_data16[m]); else pass++;
            chk++; if (rx_level16[m] !== 3'd1) $display("FAIL mode%0d_rx_level got %0d exp 1", m, rx_level16[m]); else pass++;
            rx_ready16[m] = 1'b1;
            @(negedge clk);
            rx_ready16[m] = 1'b0;
        end
    endtask

    task automatic test_overrun();
        frame_begin(4);
        for (int w = 1; w <= 6; w++) begin
            xfer(4, 8, 16'(8'h10 + w), mi);
            chk++; if (mi[7:0] !== 8'hFF) $display("FAIL ovr_idle_word%0d got %h exp ff", w, mi[7:0]); else pass++;
        end
        frame_end(4);
        chk++; if (if8.rx_level !== 3'd4) $display("FAIL ovr_rx_level got %0d exp 4", if8.rx_level); else pass++;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        chk++; if (ov8 !== 1'b1) $display("FAIL ovr_flag got %b exp 1", ov8); else pass++;
`endif
        for (int k = 1; k <= 4; k++) begin
            chk++; if (if8.rx_data !== 8'(8'h10 + k)) $display("FAIL ovr_word%0d got %h exp %h", k, if8.rx_data, 8'(8'h10 + k)); else pass++;
            pop8();
        end
        chk++; if (if8.rx_valid !== 1'b0) $display("FAIL ovr_drained got %b exp 0", if8.rx_valid); else pass++;
    endtask

    task automatic test_underrun();
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk++; if ({ov8, un8} !== 2'b00) $display("FAIL status_clr got %b exp 00", {ov8, un8}); else pass++;
`endif
        frame_begin(4);
        xfer(4, 8, 16'h0011, mi);
        chk++; if (mi[7:0] !== 8'hFF) $display("FAIL udr_word1 got %h exp ff", mi[7:0]); else pass++;
        xfer(4, 8, 16'h0022, mi);
        chk++; if (mi[7:0] !== 8'hFF) $display("FAIL udr_word2 got %h exp ff", mi[7:0]); else pass++;
        frame_end(4);
        chk++; if (if8.rx_level !== 3'd2) $display("FAIL udr_rx_level got %0d exp 2", if8.rx_level); else pass++;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        chk++; if (un8 !== 1'b1) $display("FAIL udr_flag got %b exp 1", un8); else pass++;
`endif
    endtask

    task automatic test_partial();
        int base;
        base = wd_cnt;
        frame_begin(4);
        xfer(4, 5, 16'h001F, mi);
        frame_end(4);
        chk++; if (if8.rx_level !== 3'd2) $display("FAIL part_rx_level got %0d exp 2", if8.rx_level); else pass++;
        chk++; if (miso_p[4] !== 1'b0) $display("FAIL part_miso got %b exp 0", miso_p[4]); else pass++;
        chk++; if (wd_cnt !== base) $display("FAIL part_word_done got %0d exp %0d", wd_cnt, base); else pass++;
        push8(8'h5A);
        frame_begin(4);
        xfer(4, 8, 16'h0096, mi);
        frame_end(4);
        chk++; if (mi[7:0] !== 8'h5A) $display("FAIL part_next_miso got %h exp 5a", mi[7:0]); else pass++;
        chk++; if (if8.rx_level !== 3'd3) $display("FAIL part_next_level got %0d exp 3", if8.rx_level); else pass++;
        chk++; if (if8.rx_data !== 8'h11) $display("FAIL part_head got %h exp 11", if8.rx_data); else pass++;
        pop8();
        pop8();
        chk++; if (if8.rx_data !== 8'h96) $display("FAIL part_next_rx got %h exp 96", if8.rx_data); else pass++;
        pop8();
    endtask

    task automatic test_reset_mid();
        frame_begin(4);
        xfer(4, 8, 16'h0077, mi);
        xfer(4, 8, 16'h0078, mi);
        frame_end(4);
        push8(8'hC1);
        push8(8'hC2);
        chk++; if ({if8.rx_level, if8.tx_level} !== {3'd2, 3'd2}) $display("FAIL mid_levels got %0d/%0d exp 2/2", if8.rx_level, if8.tx_level); else pass++;
        frame_begin(4);
        xfer(4, 3, 16'h0005, mi);
        rst = 1'b1;
        #1;
        chk++; if ({if8.rx_level, if8.tx_level} !== 6'd0) $display("FAIL mid_rst_levels got %0d/%0d exp 0/0", if8.rx_level, if8.tx_level); else pass++;
        chk++; if ({if8.rx_valid, if8.tx_ready} !== 2'b01) $display("FAIL mid_rst_flags got %b exp 01", {if8.rx_valid, if8.tx_ready}); else pass++;
        chk++; if ({busy8, wd8, miso_p[4]} !== 3'b000) $display("FAIL mid_rst_outs got %b exp 000", {busy8, wd8, miso_p[4]}); else pass++;
        ss_p[4] = 1'b1;
        #50;
        @(negedge clk);
        rst = 1'b0;
        push8(8'hC3);
        frame_begin(4);
        xfer(4, 8, 16'h0069, mi);
        frame_end(4);
        chk++; if (mi[7:0] !== 8'hC3) $display("FAIL mid_new_miso got %h exp c3", mi[7:0]); else pass++;
        chk++; if (if8.rx_data !== 8'h69) $display("FAIL mid_new_rx got %h exp 69", if8.rx_data); else pass++;
        chk++; if (if8.rx_level !== 3'd1) $display("FAIL mid_new_level got %0d exp 1", if8.rx_level); else pass++;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
        chk++; if (fc8 !== 16'd1) $display("FAIL mid_frame_cnt got %0d exp 1", fc8); else pass++;
`endif
    endtask

    initial begin
        if8.rx_ready = 1'b0;
        if8.tx_valid = 1'b0;
        if8.tx_data = '0;
        for (int i = 0; i < 4; i++) tx_data16[i] = '0;
        #30;
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_mode0();
        test_modes16();
        test_overrun();
        test_underrun();
        test_partial();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
